donut_ray_sched: RTL

//  Upstream sequencer and downstream shader for the donut hit-test stage.

---
 rtl/donut_ray_sched.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/donut_ray_sched.sv
// Pixel-grid ray sequencer and 2-bit shader for the donut hit-test stage.
// Optional ordered dither before the clamp: define DONUT_SHADE_DITHER_EN.
module donut_ray_sched #(
  parameter int unsigned        HRES  = 160,
  parameter int unsigned        VRES  = 120,
  parameter int unsigned        ITERS = 8,
  parameter logic signed [15:0] RX0   = -16'sd80,
  parameter logic signed [15:0] RY0   = -16'sd60,
  parameter logic signed [15:0] RZ    = 16'sd256,
  parameter logic signed [15:0] DX    = 16'sd1,
  parameter logic signed [15:0] DY    = 16'sd1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               frame_start,
  input  logic signed [15:0] cam_px,
  input  logic signed [15:0] cam_py,
  input  logic signed [15:0] cam_pz,
  output logic               start,
  output logic signed [15:0] px,
  output logic signed [15:0] py,
  output logic signed [15:0] pz,
  output logic signed [15:0] rx,
  output logic signed [15:0] ry,
  output logic signed [15:0] rz,
  input  logic               hit_in,
  input  logic signed [15:0] light_in,
  output logic               shade_valid,
  input  logic               shade_ready,
  output logic [1:0]         shade,
  output logic               shade_hit,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic               frame_done
);

  localparam int unsigned CW = $clog2(ITERS + 1);
  localparam int unsigned PW = 10;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_MARCH, S_OUT} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_x, r_y, w_x_nxt, w_y_nxt;
  logic signed [DW-1:0] r_dx, r_dy, w_dx_nxt, w_dy_nxt;
  logic                r_done;
  logic                w_capture, w_done_pulse, w_restart, w_accept, w_launch, w_last;
  logic [7:0]          w_dither;
  logic [16:0]         w_v;
  logic [1:0]          w_shade;

  logic                 r_start, r_shade_valid, r_shade_hit, r_frame_done;
  logic signed [DW-1:0] r_px, r_py, r_pz, r_rx, r_ry, r_rz;
  logic [1:0]           r_shade;
  logic [PW-1:0]        r_pix_x, r_pix_y;

  assign w_last = (r_x == PW'(HRES - 1)) && (r_y == PW'(VRES - 1));

  // Next state; frame_start overrides every other decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_done_pulse = 1'b0;
    w_restart    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE:   if (run && !r_done) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_MARCH;
      S_MARCH: begin
        if (r_cnt == CW'(ITERS)) begin
          w_state_nxt = S_OUT;
          w_capture   = 1'b1;
        end
      end
      S_OUT: begin
        if (shade_ready) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_done_pulse = 1'b1;
            w_state_nxt  = S_IDLE;
          end else if (run) begin
            w_state_nxt = S_LAUNCH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (frame_start) begin
      w_state_nxt  = S_LAUNCH;
      w_restart    = 1'b1;
      w_capture    = 1'b0;
      w_done_pulse = 1'b0;
    end
    w_launch = (w_state_nxt == S_LAUNCH);
  end

  // Pixel position and incremental ray direction for the next launch.
  always_comb begin
    w_x_nxt  = r_x;
    w_y_nxt  = r_y;
    w_dx_nxt = r_dx;
    w_dy_nxt = r_dy;
    if (w_restart) begin
      w_x_nxt  = '0;
      w_y_nxt  = '0;
      w_dx_nxt = RX0;
      w_dy_nxt = RY0;
    end else if (w_accept) begin
      if (r_x == PW'(HRES - 1)) begin
        w_x_nxt  = '0;
        w_dx_nxt = RX0;
        if (w_last) begin
          w_y_nxt  = '0;
          w_dy_nxt = RY0;
        end else begin
          w_y_nxt  = r_y + PW'(1);
          w_dy_nxt = r_dy + DY;
        end
      end else begin
        w_x_nxt  = r_x + PW'(1);
        w_dx_nxt = r_dx + DX;
      end
    end
  end

`ifdef DONUT_SHADE_DITHER_EN
  always_comb begin
    case ({r_y[0], r_x[0]})
      2'b00:   w_dither = 8'd0;
      2'b01:   w_dither = 8'd32;
      2'b10:   w_dither = 8'd48;
      default: w_dither = 8'd16;
    endcase
  end
`else
  assign w_dither = 8'd0;
`endif

  // Widened add so a large positive light plus offset cannot wrap before the clamp.
  assign w_v = {1'b0, light_in} + 17'(w_dither);

  always_comb begin
    w_shade = 2'd0;
    if (hit_in && !light_in[15]) begin
      if (w_v > 17'd255) w_shade = 2'd3;
      else               w_shade = w_v[7:6];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_dx          <= RX0;
      r_dy          <= RY0;
      r_done        <= 1'b0;
      r_start       <= 1'b0;
      r_px          <= '0;
      r_py          <= '0;
      r_pz          <= '0;
      r_rx          <= '0;
      r_ry          <= '0;
      r_rz          <= '0;
      r_shade_valid <= 1'b0;
      r_shade       <= '0;
      r_shade_hit   <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_dx          <= w_dx_nxt;
      r_dy          <= w_dy_nxt;
      r_start       <= w_launch;
      r_shade_valid <= (w_state_nxt == S_OUT);
      r_frame_done  <= w_done_pulse;
      if (r_state == S_LAUNCH)     r_cnt <= CW'(1);
      else if (r_state == S_MARCH) r_cnt <= r_cnt + CW'(1);
      if (w_restart)         r_done <= 1'b0;
      else if (w_done_pulse) r_done <= 1'b1;
      if (w_launch) begin
        r_px <= cam_px;
        r_py <= cam_py;
        r_pz <= cam_pz;
        r_rx <= w_dx_nxt;
        r_ry <= w_dy_nxt;
        r_rz <= RZ;
      end
      if (w_capture) begin
        r_shade     <= w_shade;
        r_shade_hit <= hit_in;
        r_pix_x     <= r_x;
        r_pix_y     <= r_y;
      end
    end
  end

  assign start       = r_start;
  assign px          = r_px;
  assign py          = r_py;
  assign pz          = r_pz;
  assign rx          = r_rx;
  assign ry          = r_ry;
  assign rz          = r_rz;
  assign shade_valid = r_shade_valid;
  assign shade       = r_shade;
  assign shade_hit   = r_shade_hit;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_done  = r_frame_done;

endmodule
